// File: rtl/im_mem_arbiter_pkg.sv
// im_arb_pkg: shared constants, FSM states and frame-buffer address helper for the IM arbiter
package im_arb_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int RGB_W = 12;
  typedef enum logic [1:0] {IDLE, DRAIN, FILL} state_t;
  function automatic logic [31:0] fb_addr(input logic [9:0] x, input logic [9:0] y, input int fb_w, input int scale_log2);
    return 32'(int'(y >> scale_log2) * fb_w + int'(x >> scale_log2));
  endfunction
endpackage

// File: rtl/im_mem_arbiter_if.sv
// im_mem_arbiter_if: single-port IM RAM bus; master is the arbiter, slave is the RAM
interface im_mem_arbiter_if import im_arb_pkg::*; #(parameter int ADDR_W = 15) ();
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [RGB_W-1:0]  mem_wdata;
  logic [RGB_W-1:0]  mem_rdata;
  modport master (output mem_en, mem_we, mem_addr, mem_wdata, input mem_rdata);
  modport slave  (input mem_en, mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/im_mem_arbiter_wr_fifo.sv
// im_wr_fifo: synchronous FIFO holding buffered CPU {addr, data} writes
module im_wr_fifo #(
  parameter int DW    = 27,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);
  logic [DW-1:0] buf_q [DEPTH];
  logic [PW:0]   wp, rp;
  assign empty = wp == rp;
  assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign rdata = buf_q[rp[PW-1:0]];
  always_ff @(posedge clk)
    if (push) buf_q[wp[PW-1:0]] <= wdata;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (PW+1)'(1);
      if (pop) rp <= rp + (PW+1)'(1);
    end
endmodule

// File: rtl/im_mem_arbiter.sv
// im_mem_arbiter: shares the IM RAM between VGA scan-out reads, buffered CPU writes and a fill engine
module im_mem_arbiter import im_arb_pkg::*; #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int SCALE_LOG2 = 2,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  output logic [RGB_W-1:0]  rgb,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [RGB_W-1:0]  cpu_wdata,
  input  logic              fill_start,
  input  logic [RGB_W-1:0]  fill_color,
  output logic              busy,
  output logic              fill_done,
  output logic              err_oob,
  im_mem_arbiter_if.master  mem
);
  localparam int FB_N = FB_W * FB_H;
  localparam logic [ADDR_W:0] FB_LIM = (ADDR_W+1)'(FB_N);
  state_t            state;
  logic [ADDR_W-1:0] fill_addr, head_addr;
  logic [RGB_W-1:0]  fill_col, head_data;
  logic              full, empty, video, vid_d, blank_d, push, pop, head_ok, cpu_wr, fill_wr;
  assign video     = pix_en && pixel_x < 10'(SCREEN_W) && pixel_y < 10'(SCREEN_H);
  assign cpu_ready = !rst && !full && state == IDLE;
  assign push      = cpu_valid && cpu_ready;
  assign pop       = !rst && !video && !empty;
  assign head_ok   = {1'b0, head_addr} < FB_LIM;
  assign cpu_wr    = pop && head_ok;
  assign fill_wr   = !rst && !video && state == FILL;
  assign busy      = !rst && (!empty || state != IDLE);
  // Video slots win outright; everything else only uses the bus on free cycles.
  assign mem.mem_en    = !rst && (video || cpu_wr || fill_wr);
  assign mem.mem_we    = cpu_wr || fill_wr;
  assign mem.mem_addr  = rst ? '0 : video ? ADDR_W'(fb_addr(pixel_x, pixel_y, FB_W, SCALE_LOG2)) :
                         cpu_wr ? head_addr : fill_wr ? fill_addr : '0;
  assign mem.mem_wdata = cpu_wr ? head_data : fill_wr ? fill_col : '0;
  im_wr_fifo #(.DW(ADDR_W + RGB_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({cpu_addr, cpu_wdata}),
    .rdata ({head_addr, head_data}),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      fill_addr <= '0;
      fill_col  <= '0;
      fill_done <= 1'b0;
      err_oob   <= 1'b0;
      vid_d     <= 1'b0;
      blank_d   <= 1'b0;
      rgb       <= '0;
    end else begin
      vid_d     <= video;
      blank_d   <= pix_en && !video;
      rgb       <= vid_d ? mem.mem_rdata : blank_d ? '0 : rgb;
      fill_done <= 1'b0;
      if (pop && !head_ok) err_oob <= 1'b1;
      case (state)
        IDLE: if (fill_start) begin
          fill_col <= fill_color;
          state    <= DRAIN;
        end
        DRAIN: if (empty) state <= FILL;
        FILL: if (fill_wr) begin
          if (fill_addr == ADDR_W'(FB_N - 1)) begin
            fill_addr <= '0;
            fill_done <= 1'b1;
            state     <= IDLE;
          end else fill_addr <= fill_addr + ADDR_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_im_mem_arbiter.sv
// tb_im_mem_arbiter: directed, table-driven checks of video reads, CPU FIFO, fill engine and reset
module tb_im_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic [11:0] rgb;
  logic        cpu_valid = 1'b0;
  logic        cpu_ready;
  logic [14:0] cpu_addr = '0;
  logic [11:0] cpu_wdata = '0;
  logic        fill_start = 1'b0;
  logic [11:0] fill_color = '0;
  logic        busy, fill_done, err_oob;
  int          n_chk = 0, n_fail = 0;
  logic [11:0] ram [32768];

  im_mem_arbiter_if #(.ADDR_W(15)) mif ();

  im_mem_arbiter dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .pixel_x(pixel_x), .pixel_y(pixel_y), .rgb(rgb),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .fill_start(fill_start), .fill_color(fill_color), .busy(busy), .fill_done(fill_done),
    .err_oob(err_oob), .mem(mif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mif.mem_en && mif.mem_we) ram[mif.mem_addr] <= mif.mem_wdata;
    mif.mem_rdata <= (mif.mem_en && !mif.mem_we) ? ram[mif.mem_addr] : 12'h0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  typedef struct { logic [14:0] a; logic [11:0] d; } wr_t;
  typedef struct { logic [9:0] x; logic [9:0] y; logic en; logic [14:0] addr; logic [11:0] rgb; } vid_t;
  wr_t  wv [8];
  vid_t vv [7];

  initial begin
    int occ, sent, got, nw, bad, rdy_bad, done_cnt, done_c, lastw;
    logic vid, rdy, pushed, popped;
    wv[0] = '{15'd325,   12'hABC};
    wv[1] = '{15'd0,     12'h123};
    wv[2] = '{15'd19199, 12'h456};
    wv[3] = '{15'd1,     12'h789};
    wv[4] = '{15'd8025,  12'h5A5};
    wv[5] = '{15'd2,     12'h222};
    wv[6] = '{15'd3,     12'h333};
    wv[7] = '{15'd640,   12'h2A0};
    vv[0] = '{10'd20,  10'd10,  1'b1, 15'd325,   12'hABC};
    vv[1] = '{10'd700, 10'd10,  1'b0, 15'd0,     12'h000};
    vv[2] = '{10'd0,   10'd0,   1'b1, 15'd0,     12'h123};
    vv[3] = '{10'd639, 10'd479, 1'b1, 15'd19199, 12'h456};
    vv[4] = '{10'd20,  10'd480, 1'b0, 15'd0,     12'h000};
    vv[5] = '{10'd7,   10'd3,   1'b1, 15'd1,     12'h789};
    vv[6] = '{10'd100, 10'd200, 1'b1, 15'd8025,  12'h5A5};

    // reset state
    nxt(); nxt();
    @(negedge clk);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_mem_en", mif.mem_en, 0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rgb", rgb, 0);
    chk("post_rst_ready", cpu_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fill_done", fill_done, 0);
    chk("rst_err_oob", err_oob, 0);
    chk("rst_mem_addr", mif.mem_addr, 0);
    chk("rst_mem_wdata", mif.mem_wdata, 0);
    chk("rst_mem_we", mif.mem_we, 0);
    nxt();

    // back-to-back CPU writes with no video: each drains the cycle after its push
    for (int i = 0; i < 8; i++) begin
      cpu_valid = 1'b1; cpu_addr = wv[i].a; cpu_wdata = wv[i].d;
      @(negedge clk);
      chk("burst_ready", cpu_ready, 1);
      if (i > 0) begin
        chk("burst_we", mif.mem_we, 1);
        chk("burst_addr", mif.mem_addr, wv[i-1].a);
        chk("burst_data", mif.mem_wdata, wv[i-1].d);
      end else chk("burst_first_idle", mif.mem_en, 0);
      nxt();
    end
    cpu_valid = 1'b0;
    @(negedge clk);
    chk("burst_last_addr", mif.mem_addr, wv[7].a);
    chk("burst_last_we", mif.mem_we, 1);
    chk("burst_busy_last", busy, 1);
    nxt();
    @(negedge clk);
    chk("burst_busy_fall", busy, 0);
    chk("burst_no_extra", mif.mem_en, 0);
    nxt();

    // video read table: address at T, rgb at T+2
    for (int i = 0; i < 7; i++) begin
      pix_en = 1'b1; pixel_x = vv[i].x; pixel_y = vv[i].y;
      @(negedge clk);
      chk("vid_en", mif.mem_en, vv[i].en);
      if (vv[i].en) begin
        chk("vid_we", mif.mem_we, 0);
        chk("vid_addr", mif.mem_addr, vv[i].addr);
      end
      nxt();
      pix_en = 1'b0;
      @(negedge clk);
      chk("vid_gap_en", mif.mem_en, 0);
      nxt();
      @(negedge clk);
      chk("vid_rgb", rgb, vv[i].rgb);
      nxt();
    end

    // CPU write landing on a video slot is deferred by one cycle
    pix_en = 1'b1; pixel_x = 10'd20; pixel_y = 10'd10;
    cpu_valid = 1'b1; cpu_addr = 15'd500; cpu_wdata = 12'h5F5;
    @(negedge clk);
    chk("prio_ready", cpu_ready, 1);
    chk("prio_vid_we", mif.mem_we, 0);
    chk("prio_vid_addr", mif.mem_addr, 325);
    nxt();
    pix_en = 1'b0; cpu_valid = 1'b0;
    @(negedge clk);
    chk("prio_wr_we", mif.mem_we, 1);
    chk("prio_wr_addr", mif.mem_addr, 500);
    chk("prio_wr_data", mif.mem_wdata, 12'h5F5);
    nxt();
    @(negedge clk);
    chk("prio_rgb", rgb, 12'hABC);
    nxt();

    // FIFO fills up when pushes outrun drains between video slots every 3 clk
    occ = 0; sent = 0; got = 0;
    pixel_x = 10'd0; pixel_y = 10'd0;
    for (int c = 0; c < 60; c++) begin
      vid = (c % 3 == 0);
      pix_en = vid;
      cpu_valid = sent < 24; cpu_addr = 15'(1000 + sent); cpu_wdata = 12'(sent + 1);
      rdy = occ < 8;
      @(negedge clk);
      chk("full_ready", cpu_ready, rdy);
      popped = !vid && occ > 0;
      chk("full_we", mif.mem_we, popped);
      if (popped) begin
        chk("full_addr", mif.mem_addr, 15'(1000 + got));
        chk("full_data", mif.mem_wdata, 12'(got + 1));
        got++;
      end
      pushed = cpu_valid && rdy;
      if (pushed) sent++;
      occ = occ + int'(pushed) - int'(popped);
      nxt();
    end
    pix_en = 1'b0; cpu_valid = 1'b0;
    chk("full_total", got, 24);

    // out-of-range CPU write is dropped and flagged stickily
    cpu_valid = 1'b1; cpu_addr = 15'd19200; cpu_wdata = 12'hFFF;
    @(negedge clk);
    chk("oob_pre", err_oob, 0);
    nxt();
    cpu_valid = 1'b0;
    @(negedge clk);
    chk("oob_no_access", mif.mem_en, 0);
    chk("oob_busy", busy, 1);
    nxt();
    @(negedge clk);
    chk("oob_flag", err_oob, 1);
    chk("oob_busy_clear", busy, 0);
    nxt(); nxt();
    @(negedge clk);
    chk("oob_sticky", err_oob, 1);
    nxt();

    // full-frame fill with a concurrent CPU push and a late ignored fill_start
    nw = 0; bad = 0; rdy_bad = 0; done_cnt = 0; done_c = -1; lastw = -1;
    pixel_x = 10'd20; pixel_y = 10'd10;
    for (int c = 0; c < 30000; c++) begin
      fill_start = (c == 0 || c == 5000);
      fill_color = (c == 0) ? 12'h00F : 12'hF00;
      cpu_valid = (c == 0); cpu_addr = 15'd7; cpu_wdata = 12'h777;
      pix_en = (c % 4 == 2);
      @(negedge clk);
      if (pix_en && mif.mem_we) bad++;
      if (mif.mem_en && mif.mem_we) begin
        if (nw == 0 ? (mif.mem_addr !== 15'd7 || mif.mem_wdata !== 12'h777)
                    : (mif.mem_addr !== 15'(nw - 1) || mif.mem_wdata !== 12'h00F)) bad++;
        nw++;
        lastw = c;
      end
      if (fill_done) begin
        done_cnt++;
        done_c = c;
      end else if (c > 0 && done_cnt == 0 && cpu_ready) rdy_bad++;
      nxt();
      if (done_cnt > 0 && c >= done_c + 3) break;
    end
    fill_start = 1'b0; pix_en = 1'b0; cpu_valid = 1'b0;
    chk("fill_done_count", done_cnt, 1);
    chk("fill_write_count", nw, 19201);
    chk("fill_seq_errors", bad, 0);
    chk("fill_ready_low", rdy_bad, 0);
    chk("fill_done_timing", done_c, lastw + 1);
    @(negedge clk);
    chk("fill_end_busy", busy, 0);
    chk("fill_end_ready", cpu_ready, 1);
    nxt();

    // reset in the middle of a fill
    fill_start = 1'b1; fill_color = 12'h0F0; pixel_x = 10'd0; pixel_y = 10'd0;
    for (int c = 0; c < 50; c++) begin
      pix_en = (c % 4 == 1);
      nxt();
      fill_start = 1'b0;
    end
    pix_en = 1'b0;
    @(negedge clk);
    chk("mid_fill_busy", busy, 1);
    chk("mid_fill_rgb_nonzero", rgb != 12'h0, 1);
    nxt();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_mem_en", mif.mem_en, 0);
    chk("mid_rst_ready", cpu_ready, 0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_rgb", rgb, 0);
    chk("after_rst_busy", busy, 0);
    chk("after_rst_err", err_oob, 0);
    chk("after_rst_done", fill_done, 0);
    chk("after_rst_ready", cpu_ready, 1);
    chk("after_rst_mem_en", mif.mem_en, 0);
    chk("after_rst_addr", mif.mem_addr, 0);
    chk("after_rst_wdata", mif.mem_wdata, 0);
    nxt(); nxt();
    @(negedge clk);
    chk("after_rst_no_fill", mif.mem_en, 0);
    chk("after_rst_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
